// File: rtl/iommu_pdt_walker.sv
// Process Directory Table walker: resolves a PDTC miss by walking PD8/PD17/PD20
// and returns the 16-byte leaf process context to the PDTC, or a PDT fault cause.
module iommu_pdt_walker #(
  parameter int unsigned ADDR_W = 56
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [23:0]       did_i,
  input  logic [19:0]       pid_i,
  input  logic [3:0]        pdtp_mode_i,
  input  logic [43:0]       pdtp_ppn_i,
  output logic              busy_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i,
  input  logic              mem_err_i,
  output logic              up_valid_o,
  output logic [23:0]       up_did_o,
  output logic [19:0]       up_pid_o,
  output logic [127:0]      up_content_o,
  output logic              done_o,
  output logic              error_o,
  output logic [11:0]       cause_o,
  output logic              aborted_o
);

  localparam logic [11:0] CAUSE_PDT_ACCESS  = 12'd265;
  localparam logic [11:0] CAUSE_PDT_INVALID = 12'd266;
  localparam logic [11:0] CAUSE_PDT_MISCONF = 12'd267;

  typedef enum logic [2:0] {
    IDLE, NL_REQ, NL_WAIT, TA_REQ, TA_WAIT, FSC_REQ, FSC_WAIT, DONE
  } state_e;

  state_e       state_q, state_d;
  logic [23:0]  did_q, did_d;
  logic [19:0]  pid_q, pid_d;
  logic [43:0]  ppn_q, ppn_d;
  logic         l2_q, l2_d;
  logic         abort_q, abort_d;
  logic         hold_q, hold_d;
  logic         err_q, err_d;
  logic [11:0]  cause_q, cause_d;
  logic [63:0]  ta_q, ta_d;
  logic [63:0]  fsc_q, fsc_d;

  logic [55:0]  base_addr, nl_addr, ta_addr, addr_sel;
  logic [8:0]   nl_idx;
  logic         nl_rsvd;

  always_comb begin
    base_addr = {ppn_q, 12'h000};
    nl_idx    = l2_q ? {6'd0, pid_q[19:17]} : pid_q[16:8];
    nl_addr   = base_addr + {44'd0, nl_idx, 3'd0};
    ta_addr   = base_addr + {44'd0, pid_q[7:0], 4'd0};
    nl_rsvd   = (|mem_rdata_i[63:54]) | (|mem_rdata_i[9:1]);
  end

  // A request that was presented but not yet granted must be held even if a flush
  // arrives; an abort only prevents fresh requests from being raised.
  always_comb begin
    state_d    = state_q;
    did_d      = did_q;
    pid_d      = pid_q;
    ppn_d      = ppn_q;
    l2_d       = l2_q;
    abort_d    = abort_q | flush_i;
    err_d      = err_q;
    cause_d    = cause_q;
    ta_d       = ta_q;
    fsc_d      = fsc_q;
    mem_req_o  = 1'b0;
    addr_sel   = 56'd0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req_i) begin
          did_d   = did_i;
          pid_d   = pid_i;
          ppn_d   = pdtp_ppn_i;
          err_d   = 1'b0;
          abort_d = flush_i;
          l2_d    = (pdtp_mode_i == 4'd3);
          case (pdtp_mode_i)
            4'd1:       state_d = TA_REQ;
            4'd2, 4'd3: state_d = NL_REQ;
            default: begin
              state_d = DONE;
              err_d   = 1'b1;
              cause_d = CAUSE_PDT_MISCONF;
            end
          endcase
        end
      end
      NL_REQ, TA_REQ, FSC_REQ: begin
        if (abort_q && !hold_q) begin
          state_d = DONE;
        end else begin
          mem_req_o = 1'b1;
          if (state_q == NL_REQ)      addr_sel = nl_addr;
          else if (state_q == TA_REQ) addr_sel = ta_addr;
          else                        addr_sel = ta_addr + 56'd8;
          if (mem_gnt_i) begin
            if (state_q == NL_REQ)      state_d = NL_WAIT;
            else if (state_q == TA_REQ) state_d = TA_WAIT;
            else                        state_d = FSC_WAIT;
          end
        end
      end
      NL_WAIT: begin
        if (mem_rvalid_i) begin
          if (abort_q) begin
            state_d = DONE;
          end else if (mem_err_i) begin
            state_d = DONE;
            err_d   = 1'b1;
            cause_d = CAUSE_PDT_ACCESS;
          end else if (nl_rsvd) begin
            state_d = DONE;
            err_d   = 1'b1;
            cause_d = CAUSE_PDT_MISCONF;
          end else if (!mem_rdata_i[0]) begin
            state_d = DONE;
            err_d   = 1'b1;
            cause_d = CAUSE_PDT_INVALID;
          end else begin
            ppn_d   = mem_rdata_i[53:10];
            l2_d    = 1'b0;
            state_d = l2_q ? NL_REQ : TA_REQ;
          end
        end
      end
      TA_WAIT: begin
        if (mem_rvalid_i) begin
          if (abort_q) begin
            state_d = DONE;
          end else if (mem_err_i) begin
            state_d = DONE;
            err_d   = 1'b1;
            cause_d = CAUSE_PDT_ACCESS;
          end else begin
            ta_d    = mem_rdata_i;
            state_d = FSC_REQ;
          end
        end
      end
      FSC_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = DONE;
          if (!abort_q) begin
            if (mem_err_i) begin
              err_d   = 1'b1;
              cause_d = CAUSE_PDT_ACCESS;
            end else begin
              fsc_d = mem_rdata_i;
              if (!ta_q[0]) begin
                err_d   = 1'b1;
                cause_d = CAUSE_PDT_INVALID;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        abort_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    hold_d = mem_req_o & ~mem_gnt_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      did_q   <= '0;
      pid_q   <= '0;
      ppn_q   <= '0;
      l2_q    <= 1'b0;
      abort_q <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      cause_q <= '0;
      ta_q    <= '0;
      fsc_q   <= '0;
    end else begin
      state_q <= state_d;
      did_q   <= did_d;
      pid_q   <= pid_d;
      ppn_q   <= ppn_d;
      l2_q    <= l2_d;
      abort_q <= abort_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      ta_q    <= ta_d;
      fsc_q   <= fsc_d;
    end
  end

  // A flush landing in the DONE cycle still suppresses the update.
  assign mem_addr_o   = ADDR_W'(addr_sel);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign aborted_o    = done_o & (abort_q | flush_i);
  assign up_valid_o   = done_o & ~err_q & ~aborted_o;
  assign error_o      = done_o & err_q & ~aborted_o;
  assign cause_o      = cause_q;
  assign up_did_o     = did_q;
  assign up_pid_o     = pid_q;
  assign up_content_o = {ta_q, fsc_q};

endmodule

// File: tb/tb_iommu_pdt_walker.sv
// Directed bench for iommu_pdt_walker: memory responder with read-address scoreboard
// and a completion scoreboard checked on each done_o pulse.
module tb_iommu_pdt_walker;

  localparam int ADDR_W = 56;

  logic              clk;
  logic              rst_ni;
  logic              req_i;
  logic [23:0]       did_i;
  logic [19:0]       pid_i;
  logic [3:0]        pdtp_mode_i;
  logic [43:0]       pdtp_ppn_i;
  logic              busy_o;
  logic              flush_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [63:0]       mem_rdata_i;
  logic              mem_err_i;
  logic              up_valid_o;
  logic [23:0]       up_did_o;
  logic [19:0]       up_pid_o;
  logic [127:0]      up_content_o;
  logic              done_o;
  logic              error_o;
  logic [11:0]       cause_o;
  logic              aborted_o;

  iommu_pdt_walker #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .did_i(did_i), .pid_i(pid_i),
    .pdtp_mode_i(pdtp_mode_i), .pdtp_ppn_i(pdtp_ppn_i), .busy_o(busy_o), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .up_valid_o(up_valid_o), .up_did_o(up_did_o), .up_pid_o(up_pid_o),
    .up_content_o(up_content_o), .done_o(done_o), .error_o(error_o), .cause_o(cause_o),
    .aborted_o(aborted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model and read-address scoreboard
  logic [63:0] mem_model [logic [55:0]];
  logic [55:0] exp_addr_q [$];
  logic [55:0] err_addr = '1;
  int          gnt_delay = 0;
  int          rv_lat = 1;
  int          wait_cnt = 0;
  logic        take = 1'b0, prev_wait = 1'b0, req_seen = 1'b0;
  logic [55:0] take_addr = '0, prev_addr = '0;

  assign mem_gnt_i = mem_req_o && (wait_cnt >= gnt_delay);

  always @(negedge clk) begin
    if (prev_wait) chk("addr_hold", {mem_req_o, mem_addr_o}, {1'b1, prev_addr});
    if (mem_req_o && mem_gnt_i) begin
      if (exp_addr_q.size() == 0) chk("read_expected", 0, 1);
      else chk("read_addr", mem_addr_o, exp_addr_q.pop_front());
    end
    prev_wait <= mem_req_o && !mem_gnt_i;
    prev_addr <= mem_addr_o;
    take      <= mem_req_o && mem_gnt_i;
    take_addr <= mem_addr_o;
    req_seen  <= mem_req_o;
  end

  always begin : responder
    int   cnt;
    logic pend;
    logic [55:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
      if (take) begin
        pend = 1'b1; cnt = rv_lat; paddr = take_addr; wait_cnt = 0;
      end else if (req_seen) wait_cnt = wait_cnt + 1;
      else wait_cnt = 0;
      if (pend) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          pend         = 1'b0;
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_model.exists(paddr) ? mem_model[paddr] : 64'd0;
          mem_err_i    = (paddr == err_addr);
        end
      end
    end
  end

  // Completion scoreboard
  typedef struct {
    logic         up;
    logic         err;
    logic [11:0]  cause;
    logic         ab;
    logic [23:0]  did;
    logic [19:0]  pid;
    logic [127:0] content;
    int           lat;
  } exp_t;
  exp_t exp_q [$];

  task automatic push_exp(input logic up, input logic err, input logic [11:0] cause,
                          input logic ab, input logic [23:0] did, input logic [19:0] pid,
                          input logic [127:0] content, input int lat);
    exp_t e;
    e.up = up; e.err = err; e.cause = cause; e.ab = ab;
    e.did = did; e.pid = pid; e.content = content; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic walk(input logic [3:0] mode, input logic [43:0] ppn, input logic [23:0] did,
                      input logic [19:0] pid, input int flush_at);
    int   cyc;
    logic seen;
    exp_t e;
    pdtp_mode_i = mode; pdtp_ppn_i = ppn; did_i = did; pid_i = pid;
    req_i = 1'b1; flush_i = (flush_at == 0);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      req_i   = 1'b0;
      flush_i = (cyc == flush_at);
      @(negedge clk);
      if (cyc == 1) chk("busy_after_accept", busy_o, 1);
      if (done_o) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    e = exp_q.pop_front();
    chk("latency", cyc, e.lat);
    chk("up_valid", up_valid_o, e.up);
    chk("error", error_o, e.err);
    chk("aborted", aborted_o, e.ab);
    if (e.err) chk("cause", cause_o, e.cause);
    if (e.up) begin
      chk("up_did", up_did_o, e.did);
      chk("up_pid", up_pid_o, e.pid);
      chk("up_content", up_content_o, e.content);
    end
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("done_pulse", {done_o, busy_o}, 2'b00);
    chk("reads_all_seen", exp_addr_q.size(), 0);
  endtask

  localparam logic [63:0] TA1  = 64'h0000_00AB_CDEF_0001;
  localparam logic [63:0] FSC1 = 64'h0000_0000_0000_0ABC;
  localparam logic [63:0] TA2  = 64'hF000_0000_1234_5001;
  localparam logic [63:0] FSC2 = 64'h8000_0000_0000_1111;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; flush_i = 1'b0; did_i = '0; pid_i = '0;
    pdtp_mode_i = '0; pdtp_ppn_i = '0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;

    mem_model[56'h1000050] = TA1;
    mem_model[56'h1000058] = FSC1;
    mem_model[56'h2000028] = 64'h0000_0000_00C0_0001;
    mem_model[56'h3000090] = 64'h0000_0000_0100_0001;
    mem_model[56'h4000340] = TA2;
    mem_model[56'h4000348] = FSC2;
    mem_model[56'h5000018] = 64'h0000_0000_0180_0000;
    mem_model[56'h5000020] = 64'h0000_0000_0180_0021;
    mem_model[56'h5000028] = 64'h0040_0000_0180_0001;
    mem_model[56'h5000030] = 64'h0000_0000_0180_0001;
    mem_model[56'h7000100] = TA1;
    mem_model[56'h7000200] = 64'h0000_0000_0000_0002;
    mem_model[56'h7000208] = 64'h0000_0000_0000_0005;
    mem_model[56'h8000010] = TA1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_outputs", {mem_req_o, done_o, up_valid_o, error_o, aborted_o, cause_o}, 0);
    chk("rst_content", {up_content_o, up_did_o, up_pid_o}, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {busy_o, mem_req_o, done_o, mem_addr_o}, 0);

    // PD8 success
    exp_addr_q.push_back(56'h1000050); exp_addr_q.push_back(56'h1000058);
    push_exp(1, 0, 0, 0, 24'h123456, 20'h00005, {TA1, FSC1}, 5);
    walk(4'd1, 44'h1000, 24'h123456, 20'h00005, -1);

    // PD20 success, three levels
    exp_addr_q.push_back(56'h2000028); exp_addr_q.push_back(56'h3000090);
    exp_addr_q.push_back(56'h4000340); exp_addr_q.push_back(56'h4000348);
    push_exp(1, 0, 0, 0, 24'hBEEF01, 20'hA1234, {TA2, FSC2}, 9);
    walk(4'd3, 44'h2000, 24'hBEEF01, 20'hA1234, -1);

    // PD17 invalid L1 entry
    exp_addr_q.push_back(56'h5000018);
    push_exp(0, 1, 12'd266, 0, 0, 0, 0, 3);
    walk(4'd2, 44'h5000, 24'h000111, 20'h00301, -1);

    // PD17 reserved bits set, low and high fields
    exp_addr_q.push_back(56'h5000020);
    push_exp(0, 1, 12'd267, 0, 0, 0, 0, 3);
    walk(4'd2, 44'h5000, 24'h000112, 20'h00401, -1);
    exp_addr_q.push_back(56'h5000028);
    push_exp(0, 1, 12'd267, 0, 0, 0, 0, 3);
    walk(4'd2, 44'h5000, 24'h000113, 20'h00501, -1);

    // Access fault on TA read: FSC never requested
    err_addr = 56'h7000100;
    exp_addr_q.push_back(56'h7000100);
    push_exp(0, 1, 12'd265, 0, 0, 0, 0, 3);
    walk(4'd1, 44'h7000, 24'h000114, 20'h00010, -1);
    err_addr = '1;

    // Leaf TA.V=0 reported after FSC read
    exp_addr_q.push_back(56'h7000200); exp_addr_q.push_back(56'h7000208);
    push_exp(0, 1, 12'd266, 0, 0, 0, 0, 5);
    walk(4'd1, 44'h7000, 24'h000115, 20'h00020, -1);

    // Unsupported modes: no memory access
    push_exp(0, 1, 12'd267, 0, 0, 0, 0, 1);
    walk(4'd0, 44'h1000, 24'h000116, 20'h00005, -1);
    push_exp(0, 1, 12'd267, 0, 0, 0, 0, 1);
    walk(4'd15, 44'h1000, 24'h000117, 20'h00005, -1);

    // Flush during NL_WAIT with delayed grant and slow data: read drained, then abort
    gnt_delay = 3; rv_lat = 3;
    exp_addr_q.push_back(56'h5000030);
    push_exp(0, 0, 0, 1, 0, 0, 0, 8);
    walk(4'd2, 44'h5000, 24'h000118, 20'h00601, 5);
    gnt_delay = 0; rv_lat = 1;

    // Flush in the accept cycle: no read at all
    push_exp(0, 0, 0, 1, 0, 0, 0, 2);
    walk(4'd1, 44'h1000, 24'h000119, 20'h00005, 0);

    // Flush coinciding with DONE suppresses the update
    exp_addr_q.push_back(56'h1000050); exp_addr_q.push_back(56'h1000058);
    push_exp(0, 0, 0, 1, 0, 0, 0, 5);
    walk(4'd1, 44'h1000, 24'h00011A, 20'h00005, 5);

    // Flush in IDLE without a request is ignored
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("idle_flush_busy", busy_o, 0);
    exp_addr_q.push_back(56'h1000050); exp_addr_q.push_back(56'h1000058);
    push_exp(1, 0, 0, 0, 24'h00011B, 20'h00005, {TA1, FSC1}, 5);
    walk(4'd1, 44'h1000, 24'h00011B, 20'h00005, -1);

    // Async reset during TA_WAIT, late rvalid afterwards
    rv_lat = 3;
    exp_addr_q.push_back(56'h8000010);
    pdtp_mode_i = 4'd1; pdtp_ppn_i = 44'h8000; did_i = 24'h00011C; pid_i = 20'h00001;
    req_i = 1'b1;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_busy", {busy_o, mem_req_o, done_o}, 0);
    chk("midrst_regs", {up_did_o, up_pid_o, cause_o}, 0);
    chk("midrst_content", up_content_o, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("late_rvalid_present", mem_rvalid_i, 1);
    chk("late_rvalid_idle", {busy_o, mem_req_o, done_o}, 0);
    @(negedge clk);
    chk("after_late_rvalid", {busy_o, mem_req_o, done_o, up_valid_o, error_o, aborted_o}, 0);
    chk("after_late_regs", {up_content_o, up_did_o}, 0);
    chk("reset_reads_seen", exp_addr_q.size(), 0);
    rv_lat = 1;

    exp_addr_q.push_back(56'h1000050); exp_addr_q.push_back(56'h1000058);
    push_exp(1, 0, 0, 0, 24'h00011D, 20'h00005, {TA1, FSC1}, 5);
    walk(4'd1, 44'h1000, 24'h00011D, 20'h00005, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
